// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_ctrl_pkg
//  Purpose  : Shared types and constants for the ram_arbiter slice
//             (controller state, requester id, read pipeline latency).
//  Revision : 1.0  initial release
// ============================================================================
package ram_ctrl_pkg;

  // Controller state: sweeping the RAM with INIT_VALUE, or serving clients.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Identifies which requester an access belongs to.
  typedef logic [0:0] port_id_t;

  // Grant-to-response latency of a read, in clock cycles.
  localparam int unsigned RD_LAT = 2;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : Client-side bus of ram_arbiter: two request/grant ports plus
//             the shared read-response channel.
//  Modports : slave  - arbiter side (takes requests, returns gnt/rvalid/rdata)
//             master - client side (issues requests, observes responses)
//  Revision : 1.0  initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter with combinational one-hot grant.
//             On a conflict the port that was not granted most recently wins.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             req[1:0]    - request per port
//             en          - grants are only issued while high
//             gnt[1:0]    - one-hot grant, same cycle as req
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Port granted most recently; resets to 1 so port 0 wins the first conflict.
  port_id_t r_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_last == port_id_t'(1'b1)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= port_id_t'(1'b1);
    end else if (|gnt) begin
      r_last <= port_id_t'(gnt[1]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one synchronous single-port RAM between two clients.
//             After reset or a clr pulse it writes INIT_VALUE to every word,
//             then grants one access per cycle (round-robin) and returns read
//             data RD_LAT cycles after the grant.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             clr          - one-cycle pulse restarting the init sweep
//             init_done    - high once the sweep has completed
//             bus          - client request/grant/response bus (slave side)
//             ram_addr     - RAM address (registered)
//             ram_wdata    - RAM write data (registered)
//             ram_we       - RAM write enable (registered)
//             ram_rdata    - RAM registered read data
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  init_done,
  ram_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;

  logic                  w_arb_en;
  logic [1:0]            w_gnt;
  port_id_t              w_gnt_id;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_rd_issue;

  // Read tag pipeline: stage RD_LAT-1 lines up with the RAM's registered output.
  logic     [RD_LAT-1:0] r_tag_vld;
  port_id_t [RD_LAT-1:0] r_tag_id;

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = INIT;
    end else if ((r_state == INIT) && (r_cnt == c_last_addr)) begin
      w_state_nxt = RUN;
    end
  end

  assign init_done = (r_state == RUN);

  // Sweep counter; wraps back to 0 on the cycle that leaves INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration and access select
  // --------------------------------------------------------------------------
  // A request arriving together with clr is refused.
  assign w_arb_en = (r_state == RUN) && !clr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.req1, bus.req0}),
    .en    (w_arb_en),
    .gnt   (w_gnt)
  );

  assign bus.gnt0    = w_gnt[0];
  assign bus.gnt1    = w_gnt[1];
  assign w_gnt_id    = port_id_t'(w_gnt[1]);
  assign w_sel_we    = w_gnt[1] ? bus.we1    : bus.we0;
  assign w_sel_addr  = w_gnt[1] ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_gnt[1] ? bus.wdata1 : bus.wdata0;
  assign w_rd_issue  = (|w_gnt) && !w_sel_we;

  // --------------------------------------------------------------------------
  // RAM port registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if ((r_state == INIT) && !clr) begin
      ram_we    <= 1'b1;
      ram_addr  <= r_cnt;
      ram_wdata <= INIT_VALUE;
    end else if (|w_gnt) begin
      ram_we    <= w_sel_we;
      ram_addr  <= w_sel_addr;
      ram_wdata <= w_sel_wdata;
    end else begin
      // Idle: address and data hold so the RAM output stays stable.
      ram_we    <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read response pipeline (unaffected by clr so granted reads still complete)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[RD_LAT-2:0], w_rd_issue};
      r_tag_id  <= {r_tag_id[RD_LAT-2:0], w_gnt_id};
    end
  end

  assign bus.rvalid0 = r_tag_vld[RD_LAT-1] && (r_tag_id[RD_LAT-1] == port_id_t'(1'b0));
  assign bus.rvalid1 = r_tag_vld[RD_LAT-1] && (r_tag_id[RD_LAT-1] == port_id_t'(1'b1));
  assign bus.rdata   = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter with a behavioural ram1
//             model, directed stimulus and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_we;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] ram_mem [1<<AW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .init_done (init_done),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  // ram1: synchronous single port, registered read of the old contents.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},     32'(ram_we),      32'd0);
    chk({tag, "_addr"},   32'(ram_addr),    32'd0);
    chk({tag, "_wdata"},  32'(ram_wdata),   32'd0);
    chk({tag, "_done"},   32'(init_done),   32'd0);
    chk({tag, "_rvalid"}, 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
  endtask

  // One bus cycle: drive requests, check the grant against the hand-computed
  // value, and record the expected effect of each granted access.
  task automatic do_cycle(input logic r0, input logic w0, input logic [AW-1:0] a0,
                          input logic [DW-1:0] d0,
                          input logic r1, input logic w1, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d1,
                          input logic [1:0] exp_g, input string tag);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    @(negedge clk);
    chk(tag, 32'({bus.gnt1, bus.gnt0}), 32'(exp_g));
    if (exp_g[0]) begin
      if (w0) ref_mem[a0] = d0;
      else    sb_q.push_back('{id: 1'b0, data: ref_mem[a0], due: cyc + 2});
    end
    if (exp_g[1]) begin
      if (w1) ref_mem[a1] = d1;
      else    sb_q.push_back('{id: 1'b1, data: ref_mem[a1], due: cyc + 2});
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rvalid0 || bus.rvalid1) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_port",  32'({bus.rvalid1, bus.rvalid0}), mon_e.id ? 32'd2 : 32'd1);
        chk("rsp_data",  32'(bus.rdata), 32'(mon_e.data));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    ref_clear();

    // Reset and first init sweep; requests held high must not be granted.
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      @(posedge clk); #1;
      chk("init_we",    32'(ram_we),    32'd1);
      chk("init_addr",  32'(ram_addr),  32'(i));
      chk("init_wdata", 32'(ram_wdata), 32'd0);
      chk("init_done",  32'(init_done), (i == 15) ? 32'd1 : 32'd0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Port 0: write i+10 to every address, then read them back-to-back.
    for (int i = 0; i < 16; i++)
      do_cycle(1'b1, 1'b1, AW'(i), DW'(i + 10), 1'b0, 1'b0, '0, '0, 2'b01, "wr0_gnt");
    for (int i = 0; i < 16; i++)
      do_cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, 2'b01, "rd0_gnt");

    // Port 1 alone writes addr 3, making port 1 the last granted.
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd3, 8'h33, 2'b10, "wr1_gnt");

    // Continuous contention: grants alternate starting with port 0.
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd4, '0,
               (i % 2 == 0) ? 2'b01 : 2'b10, "rr_gnt");

    // Write by port 0 immediately followed by a read of it by port 1.
    do_cycle(1'b1, 1'b1, 4'd5, 8'hAA, 1'b0, 1'b0, '0, '0, 2'b01, "raw_wr_gnt");
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0, 2'b10, "raw_rd_gnt");
    repeat (3) @(posedge clk);
    #1;

    // clr one cycle after a read grant: read completes, new sweep runs.
    do_cycle(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0, 2'b01, "pre_clr_gnt");
    clr = 1'b1;
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd6, '0, 2'b00, "clr_nogrant");
    clr = 1'b0;
    ref_clear();
    chk("clr_done_low", 32'(init_done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("clr_sweep_we",   32'(ram_we),   32'd1);
      chk("clr_sweep_addr", 32'(ram_addr), 32'(i));
    end
    chk("clr_done_high", 32'(init_done), 32'd1);
    do_cycle(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0, 2'b01, "post_clr_gnt");
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a sweep.
    clr = 1'b1;
    do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 2'b00, "clr2_idle");
    clr = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_sweep");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("reinit_done", 32'(init_done), 32'd1);

    // Asynchronous reset while a read is in flight: it must never return.
    do_cycle(1'b1, 1'b0, 4'd9, 8'h5C, 1'b0, 1'b0, '0, '0, 2'b01, "pre_rst_gnt");
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset("rst_read");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
